// File: rtl/water_level_controller_pkg.sv
// Shared definitions for the reservoir water level controller: FSM state
// codes, level class codes (also used by the level display decoder),
// error codes, the probe bundle and the probe-pattern classifier.
package water_level_controller_pkg;

    localparam int unsigned PROBE_W = 3;
    localparam int unsigned CODE_W  = 2;

    // FSM state codes as seen on the state output
    typedef enum logic [CODE_W-1:0] {
        ST_IDLE       = 2'd0,
        ST_FILLING    = 2'd1,
        ST_IRRIGATING = 2'd2,
        ST_ERROR      = 2'd3
    } state_e;

    // Level classes, ordered so that a numeric compare means "lower than"
    typedef enum logic [CODE_W-1:0] {
        LVL_EMPTY = 2'd0,
        LVL_LOW   = 2'd1,
        LVL_MID   = 2'd2,
        LVL_HIGH  = 2'd3
    } level_e;

    // Error codes reported while in ERROR
    typedef enum logic [CODE_W-1:0] {
        ERR_NONE    = 2'd0,
        ERR_INVALID = 2'd1,
        ERR_TIMEOUT = 2'd2,
        ERR_RSVD    = 2'd3
    } err_e;

    // Probe bundle, MSB first as {h,m,l}
    typedef struct packed {
        logic h;
        logic m;
        logic l;
    } probe_t;

    // Classifier result: valid=0 marks a non-monotonic (impossible) pattern
    typedef struct packed {
        logic   valid;
        level_e level;
    } level_class_t;

    // Wet probes must form a contiguous run from the bottom probe upward
    function automatic level_class_t classify_probes(input probe_t p);
        level_class_t c;
        c.valid = 1'b1;
        c.level = LVL_EMPTY;
        case ({p.h, p.m, p.l})
            3'b000:  c.level = LVL_EMPTY;
            3'b001:  c.level = LVL_LOW;
            3'b011:  c.level = LVL_MID;
            3'b111:  c.level = LVL_HIGH;
            default: c.valid = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/water_level_controller_level_debouncer.sv
// Probe front end: two-flop synchroniser per probe, debounce counter on the
// synchronised pattern and classification of the accepted pattern.
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   probes_i       raw asynchronous probe bundle {h,m,l}
//   level_o        last valid accepted level class
//   level_valid_o  a pattern has been accepted since reset (sticky)
//   inv_flag_o     the currently accepted pattern is non-monotonic
module level_debouncer
    import water_level_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DB_W            = 3
) (
    input  logic   clk,
    input  logic   rst_n,
    input  probe_t probes_i,
    output level_e level_o,
    output logic   level_valid_o,
    output logic   inv_flag_o
);

    probe_t            sync1_q, sync2_q;
    logic [1:0]        warm_q, warm_d;
    probe_t            cand_q, cand_d;
    logic [DB_W-1:0]   cnt_q, cnt_d;
    level_e            level_q, level_d;
    logic              valid_q, valid_d;
    logic              inv_q, inv_d;
    level_class_t      cls;

    // Candidate tracking and acceptance. warm_q keeps the debouncer idle
    // until the synchroniser holds genuine post-reset probe samples, so a
    // pattern present at reset release is accepted on the same edge count
    // as any later change.
    always_comb begin
        warm_d  = {warm_q[0], 1'b1};
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        valid_d = valid_q;
        inv_d   = inv_q;
        cls     = classify_probes(sync2_q);
        if (warm_q[1]) begin
            if (sync2_q != cand_q) begin
                cand_d = sync2_q;
                cnt_d  = DB_W'(1);
            end else if (cnt_q < DB_W'(DEBOUNCE_CYCLES)) begin
                cnt_d = cnt_q + DB_W'(1);
                if (cnt_d == DB_W'(DEBOUNCE_CYCLES)) begin
                    valid_d = 1'b1;
                    if (cls.valid) begin
                        level_d = cls.level;
                        inv_d   = 1'b0;
                    end else begin
                        inv_d   = 1'b1;
                    end
                end
            end
        end
    end

    // Synchroniser and debouncer state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            warm_q  <= '0;
            cand_q  <= '0;
            cnt_q   <= '0;
            level_q <= LVL_EMPTY;
            valid_q <= 1'b0;
            inv_q   <= 1'b0;
        end else begin
            sync1_q <= probes_i;
            sync2_q <= sync1_q;
            warm_q  <= warm_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            valid_q <= valid_d;
            inv_q   <= inv_d;
        end
    end

    assign level_o       = level_q;
    assign level_valid_o = valid_q;
    assign inv_flag_o    = inv_q;

endmodule

// File: rtl/water_level_controller.sv
// Reservoir water level controller: sequences the fill valve and the
// irrigation valve from the debounced tank level, with a fill-timeout
// watchdog and an operator-acknowledged error state. All outputs are
// registered and depend only on the FSM state (Moore).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   h, m, l        raw high/medium/low probe inputs (asynchronous)
//   irrigate_req   level-sensitive irrigation request
//   alarm_ack      operator acknowledge, only honoured in ERROR
//   fill_valve     inlet valve / pump enable
//   irrig_valve    irrigation valve enable
//   alarm          fault indicator
//   state          FSM state code
//   level          debounced level class
//   err_code       0 none, 1 invalid probe pattern, 2 fill timeout
module water_level_controller
    import water_level_controller_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned DB_W            = 3,
    parameter int unsigned FILL_TIMEOUT    = 1000,
    parameter int unsigned TO_W            = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              h,
    input  logic              m,
    input  logic              l,
    input  logic              irrigate_req,
    input  logic              alarm_ack,
    output logic              fill_valve,
    output logic              irrig_valve,
    output logic              alarm,
    output logic [CODE_W-1:0] state,
    output logic [CODE_W-1:0] level,
    output logic [CODE_W-1:0] err_code
);

    probe_t          probes_raw;
    level_e          lvl;
    logic            lvl_valid;
    logic            inv_flag;

    state_e          state_q, state_d;
    err_e            err_q, err_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            fill_q, fill_d;
    logic            irrig_q, irrig_d;
    logic            alarm_q, alarm_d;

    assign probes_raw = {h, m, l};

    level_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .DB_W            (DB_W)
    ) u_level_debouncer (
        .clk           (clk),
        .rst_n         (rst_n),
        .probes_i      (probes_raw),
        .level_o       (lvl),
        .level_valid_o (lvl_valid),
        .inv_flag_o    (inv_flag)
    );

    // Next-state logic. In every non-ERROR state an invalid probe pattern
    // outranks the watchdog, which outranks normal level transitions,
    // except that reaching HIGH on the final FILLING cycle still counts.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (lvl_valid) begin
                    if (inv_flag) begin
                        state_d = ST_ERROR;
                        err_d   = ERR_INVALID;
                    end else if (lvl <= LVL_LOW) begin
                        state_d  = ST_FILLING;
                        to_cnt_d = '0;
                    end else if (irrigate_req) begin
                        state_d = ST_IRRIGATING;
                    end
                end
            end
            ST_FILLING: begin
                if (inv_flag) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_INVALID;
                end else if (lvl == LVL_HIGH) begin
                    state_d = irrigate_req ? ST_IRRIGATING : ST_IDLE;
                end else if (to_cnt_q == TO_W'(FILL_TIMEOUT - 1)) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_TIMEOUT;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            ST_IRRIGATING: begin
                if (inv_flag) begin
                    state_d = ST_ERROR;
                    err_d   = ERR_INVALID;
                end else if (lvl == LVL_EMPTY) begin
                    // refill all the way to HIGH before irrigating again
                    state_d  = ST_FILLING;
                    to_cnt_d = '0;
                end else if (!irrigate_req) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ERROR: begin
                if (alarm_ack && !inv_flag) begin
                    state_d = ST_IDLE;
                    err_d   = ERR_NONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = ERR_NONE;
            end
        endcase

        // Outputs follow the state being entered so they change on the
        // transition edge itself; the two valves are mutually exclusive.
        fill_d  = (state_d == ST_FILLING);
        irrig_d = (state_d == ST_IRRIGATING);
        alarm_d = (state_d == ST_ERROR);
    end

    // FSM state, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            err_q    <= ERR_NONE;
            to_cnt_q <= '0;
            fill_q   <= 1'b0;
            irrig_q  <= 1'b0;
            alarm_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            to_cnt_q <= to_cnt_d;
            fill_q   <= fill_d;
            irrig_q  <= irrig_d;
            alarm_q  <= alarm_d;
        end
    end

    assign fill_valve  = fill_q;
    assign irrig_valve = irrig_q;
    assign alarm       = alarm_q;
    assign state       = state_q;
    assign level       = lvl;
    assign err_code    = err_q;

endmodule

// File: tb/tb_water_level_controller.sv
// Bench for water_level_controller: a behavioural level/FSM model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_water_level_controller;

    localparam int DB = 4;
    localparam int FT = 50;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       h = 1'b0, m = 1'b0, l = 1'b0;
    logic       irrigate_req = 1'b0;
    logic       alarm_ack = 1'b0;
    logic       fill_valve, irrig_valve, alarm;
    logic [1:0] state, level, err_code;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    water_level_controller #(
        .DEBOUNCE_CYCLES (DB),
        .DB_W            (3),
        .FILL_TIMEOUT    (FT),
        .TO_W            (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .h            (h),
        .m            (m),
        .l            (l),
        .irrigate_req (irrigate_req),
        .alarm_ack    (alarm_ack),
        .fill_valve   (fill_valve),
        .irrig_valve  (irrig_valve),
        .alarm        (alarm),
        .state        (state),
        .level        (level),
        .err_code     (err_code)
    );

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Level: the pattern seen at edge k is the raw value sampled at edge k-2;
    // it is accepted once four such consecutive samples agree.
    int m_st, m_lvl, m_err, m_age;
    bit m_valid, m_inv, m_live;
    int hist[$];

    function automatic int cls_of(input int p);
        case (p)
            0: return 0;
            1: return 1;
            3: return 2;
            7: return 3;
            default: return -1;
        endcase
    endfunction

    always @(posedge clk) begin
        m_live = 1'b1;
        if (!rst_n) begin
            m_st = 0; m_lvl = 0; m_err = 0; m_age = 0;
            m_valid = 1'b0; m_inv = 1'b0;
            hist.delete();
        end else begin
            // controller decision uses the level known before this edge
            case (m_st)
                0: if (m_valid) begin
                       if (m_inv)             begin m_st = 3; m_err = 1; end
                       else if (m_lvl <= 1)   begin m_st = 1; m_age = 0; end
                       else if (irrigate_req)       m_st = 2;
                   end
                1: begin
                       m_age++;
                       if (m_inv)             begin m_st = 3; m_err = 1; end
                       else if (m_lvl == 3)   m_st = irrigate_req ? 2 : 0;
                       else if (m_age == FT)  begin m_st = 3; m_err = 2; end
                   end
                2: begin
                       if (m_inv)             begin m_st = 3; m_err = 1; end
                       else if (m_lvl == 0)   begin m_st = 1; m_age = 0; end
                       else if (!irrigate_req)      m_st = 0;
                   end
                default: if (alarm_ack && !m_inv) begin m_st = 0; m_err = 0; end
            endcase
            hist.push_back(int'({h, m, l}));
            if (hist.size() > DB + 2) void'(hist.pop_front());
            if (hist.size() == DB + 2 && hist[0] == hist[1] &&
                hist[1] == hist[2] && hist[2] == hist[3]) begin
                m_valid = 1'b1;
                if (cls_of(hist[0]) < 0) m_inv = 1'b1;
                else begin m_inv = 1'b0; m_lvl = cls_of(hist[0]); end
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (m_live) begin
            chk("state",       int'(state),       m_st);
            chk("level",       int'(level),       m_lvl);
            chk("err_code",    int'(err_code),    m_err);
            chk("fill_valve",  int'(fill_valve),  int'(m_st == 1));
            chk("irrig_valve", int'(irrig_valve), int'(m_st == 2));
            chk("alarm",       int'(alarm),       int'(m_st == 3));
        end
    end

    // ---------------- directed stimulus ----------------
    bit [3:0] lvl_seen, st_seen;

    task automatic hold(input int p, input int n);
        {h, m, l} = 3'(p);
        repeat (n) begin
            @(negedge clk);
            lvl_seen[level] = 1'b1;
            st_seen[state]  = 1'b1;
        end
    endtask

    task automatic edges_until_state(input int target, output int found);
        found = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (int'(state) == target) begin
                found = i;
                break;
            end
        end
    endtask

    initial begin
        int n;
        {h, m, l} = 3'b000;
        repeat (3) @(negedge clk);
        chk("reset_state", int'(state), 0);
        chk("reset_outputs", int'({fill_valve, irrig_valve, alarm, err_code, level}), 0);

        // empty tank after reset: level_valid at edge 6, FILLING at edge 7
        rst_n = 1'b1;
        edges_until_state(1, n);
        chk("fill_entry_edge", n, 7);
        chk("fill_valve_on", int'(fill_valve), 1);

        // rise to HIGH: filling stops
        hold(1, 10); hold(3, 10); hold(7, 10);
        chk("full_idle_state", int'(state), 0);
        chk("full_fill_off", int'(fill_valve), 0);
        chk("full_level", int'(level), 3);

        // irrigate, drain down to EMPTY -> refill
        irrigate_req = 1'b1;
        hold(7, 2);
        chk("irrig_state", int'(state), 2);
        chk("irrig_valve_on", int'(irrig_valve), 1);
        hold(3, 10); hold(1, 10);
        chk("irrig_at_low", int'(state), 2);
        hold(0, 10);
        chk("drain_refill_state", int'(state), 1);
        chk("drain_valves", int'({fill_valve, irrig_valve}), 2);
        hold(7, 10);
        chk("refill_irrig_state", int'(state), 2);

        // 3-cycle glitches never change the level
        lvl_seen = '0; st_seen = '0;
        repeat (3) begin hold(3, 3); hold(7, 5); end
        chk("glitch_levels", int'(lvl_seen), 4'b1000);
        chk("glitch_states", int'(st_seen), 4'b0100);

        // 4-cycle hold is accepted
        lvl_seen = '0; st_seen = '0;
        hold(3, 4); hold(7, 10);
        chk("hold4_levels", int'(lvl_seen), 4'b1100);
        chk("hold4_states", int'(st_seen), 4'b0100);

        // empty and never refilled: watchdog fires after FT FILLING cycles
        irrigate_req = 1'b0;
        {h, m, l} = 3'b000;
        for (int i = 0; i < 30 && state != 2'd1; i++) @(negedge clk);
        n = 0;
        for (int i = 0; i < 200 && state == 2'd1; i++) begin n++; @(negedge clk); end
        chk("fill_cycles", n, FT);
        chk("timeout_state", int'(state), 3);
        chk("timeout_alarm", int'(alarm), 1);
        chk("timeout_err", int'(err_code), 2);
        chk("timeout_fill_off", int'(fill_valve), 0);
        alarm_ack = 1'b1;
        @(negedge clk);
        chk("ack_idle", int'(state), 0);
        alarm_ack = 1'b0;
        @(negedge clk);
        chk("ack_refill", int'(state), 1);

        // back to MID in IDLE, then an impossible pattern
        hold(7, 10);
        chk("mid_prep_high", int'(state), 0);
        hold(3, 10);
        chk("mid_idle_state", int'(state), 0);
        chk("mid_idle_level", int'(level), 2);
        hold(5, 10);
        chk("invalid_state", int'(state), 3);
        chk("invalid_err", int'(err_code), 1);
        chk("invalid_level_held", int'(level), 2);
        alarm_ack = 1'b1;
        hold(5, 5);
        chk("ack_while_invalid", int'(state), 3);
        alarm_ack = 1'b0;
        hold(3, 10);
        chk("valid_no_ack", int'(state), 3);
        alarm_ack = 1'b1;
        @(negedge clk);
        chk("ack_valid_idle", int'(state), 0);
        chk("ack_valid_err", int'(err_code), 0);
        alarm_ack = 1'b0;

        // reset pulse mid-irrigation
        irrigate_req = 1'b1;
        hold(7, 10);
        chk("pre_reset_irrig", int'(state), 2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", int'({state, level, err_code, fill_valve, irrig_valve, alarm}), 0);
        rst_n = 1'b1;
        edges_until_state(2, n);
        chk("post_reset_irrig_edge", n, 7);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
